if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter STALL_LIMIT, default 15, consecutive stall cycles tolerated before stall_err.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 PCWrite  input  1  1 = PC may advance; 0 = hold PC (load-use stall).
REQ-007 IF_ID_Write  input  1  1 = IF/ID register may load; 0 = hold.
REQ-008 IF_Flush  input  1  clear IF/ID register to bubble.
REQ-009 branch_or_jump_taken  input  1  redirect PC to branch_target.
REQ-010 branch_target  input  32  redirect address from MEM stage.
REQ-011 instr_in  input  32  instruction memory read data for pc_out (combinational read).
REQ-012 pc_out  output  32  current fetch address to instruction memory.
REQ-013 IF_ID_pc_plus4  output  32  registered PC+4 of fetched instruction.
REQ-014 IF_ID_instr  output  32  registered instruction.
REQ-015 IF_ID_valid  output  1  1 = IF_ID_instr is a real instruction, 0 = bubble.
REQ-016 stall_err  output  1  sticky: stall exceeded STALL_LIMIT consecutive cycles.

Function
REQ-017 PC update per rising edge, priority: branch_or_jump_taken -> {branch_target[31:2],2'b00}; else PCWrite=0 -> hold; else PC+4.
REQ-018 PC+4 SHALL be 32-bit modulo: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-019 IF/ID update priority: IF_Flush -> IF_ID_instr=NOP (32'h0), IF_ID_pc_plus4=0, IF_ID_valid=0; else IF_ID_Write=0 -> hold all three; else load instr_in, pc_out+4, valid=1.
REQ-020 Flush SHALL override stall in the same cycle for both PC and IF/ID (redirect wins over hold).
REQ-021 Latency: instruction at pc_out appears on IF_ID_instr one cycle later; first valid fetch after reset appears on the first edge after rst_n deasserts.
REQ-022 Consecutive-stall counter: increments on each edge with PCWrite=0 and branch_or_jump_taken=0, saturates at STALL_LIMIT+1, clears on any other edge.
REQ-023 stall_err SHALL set on the edge the counter reaches STALL_LIMIT+1 and remain 1 until reset.
REQ-024 PCWrite and IF_ID_Write disagreeing SHALL be honoured independently (no cross-gating).

Reset
REQ-025 rst_n low SHALL immediately force PC=RESET_PC, IF_ID_instr=0, IF_ID_pc_plus4=0, IF_ID_valid=0, stall counter=0, stall_err=0, perf counters=0.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL discard the pending action; no update on the deasserting edge itself other than normal REQ-017/019 operation.

Configuration
REQ-027 Macro IF_ID_PERF_CNT_EN: when defined, add outputs stall_cnt[15:0] (edges with PCWrite=0) and flush_cnt[15:0] (edges with IF_Flush=1), both saturating at 16'hFFFF; when undefined, these ports and counters SHALL not exist.

Structure
REQ-028 Shared package cpu_pkg SHALL hold ADDR_W=32, INSTR_W=32, NOP_INSTR=32'h0 and PC_STEP=4.
REQ-029 One sub-module pc_reg SHALL hold the PC register and next-PC mux; IF/ID register, stall counter, perf counters stay in if_id_stage.

Verification
REQ-030 Reset release, PCWrite=1, IF_ID_Write=1, instr_in=mem[pc] -> pc_out 0,4,8; IF_ID_instr=mem[0] with pc_plus4=4, valid=1 on cycle 1.
REQ-031 PCWrite=0, IF_ID_Write=0 for 1 cycle at pc_out=8 -> pc_out stays 8, IF/ID outputs unchanged, then resume at 12.
REQ-032 branch_or_jump_taken=1, IF_Flush=1, PCWrite=0, branch_target=32'h0000_0103 -> next pc_out=32'h100, IF_ID_valid=0, IF_ID_instr=0.
REQ-033 Force pc=32'hFFFF_FFFC via branch, then advance -> pc_out=0.
REQ-034 PCWrite=0 held 16 cycles (STALL_LIMIT=15) -> stall_err=1 on 16th edge, stays 1 after PCWrite=1; rst_n low clears it asynchronously.
REQ-035 With IF_ID_PERF_CNT_EN: 3 stall edges, 2 flush edges -> stall_cnt=3, flush_cnt=2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, the bubble encoding and
// the fetch step used by the PC and IF/ID logic.
package cpu_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_STEP       = 32'd4;
  localparam logic [ADDR_W-1:0]  PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Force an address onto a word boundary so the fetch PC never goes misaligned.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-PC selection.
// Selection order: taken redirect, then hold (PCWrite low), then PC+4
// (32-bit modulo, so 32'hFFFF_FFFC advances to 0).
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] next_pc;

  // Next-PC mux: a redirect wins over a hold so a flushed stall cannot pin the PC.
  always_comb begin
    next_pc = pc + PC_STEP;
    if (redirect) begin
      next_pc = align_word(redirect_target);
    end else if (!pc_write) begin
      next_pc = pc;
    end
  end

  // PC state register.
  // NOTE: state is written with <= so every flop samples pre-edge values;
  // the asynchronous reset appears in the sensitivity list so it acts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register.
// Holds the IF/ID register, a consecutive-stall watchdog (sticky stall_err)
// and, when IF_ID_PERF_CNT_EN is defined, saturating stall/flush event counters
// exposed as stall_cnt and flush_cnt.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned       STALL_LIMIT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PCWrite,
  input  logic               IF_ID_Write,
  input  logic               IF_Flush,
  input  logic               branch_or_jump_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  IF_ID_pc_plus4,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic               IF_ID_valid,
`ifdef IF_ID_PERF_CNT_EN
  output logic               stall_err,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`else
  output logic               stall_err
`endif
);

  // Counter must be able to hold STALL_LIMIT+1, where it saturates.
  localparam int unsigned ERR_LEVEL = STALL_LIMIT + 1;
  localparam int          RUN_W     = $clog2(ERR_LEVEL + 1);
  localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(ERR_LEVEL);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STALL_LIMIT);

  logic [ADDR_W-1:0] fetch_pc_plus4;
  logic [RUN_W-1:0]  stall_run;
  logic              stall_event;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_write        (PCWrite),
    .redirect        (branch_or_jump_taken),
    .redirect_target (branch_target),
    .pc              (pc_out)
  );

  assign fetch_pc_plus4 = pc_out + PC_STEP;
  // A redirect resolves the stall, so it does not count toward the watchdog.
  assign stall_event    = !PCWrite && !branch_or_jump_taken;

  // IF/ID register: flush beats hold, hold beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_instr    <= NOP_INSTR;
      IF_ID_pc_plus4 <= '0;
      IF_ID_valid    <= 1'b0;
    end else if (IF_Flush) begin
      IF_ID_instr    <= NOP_INSTR;
      IF_ID_pc_plus4 <= '0;
      IF_ID_valid    <= 1'b0;
    end else if (IF_ID_Write) begin
      IF_ID_instr    <= instr_in;
      IF_ID_pc_plus4 <= fetch_pc_plus4;
      IF_ID_valid    <= 1'b1;
    end
  end

  // Consecutive-stall watchdog; stall_err latches on reaching STALL_LIMIT+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_run <= '0;
      stall_err <= 1'b0;
    end else if (stall_event) begin
      if (stall_run != RUN_SAT) begin
        stall_run <= stall_run + RUN_W'(1);
      end
      if (stall_run == RUN_LAST) begin
        stall_err <= 1'b1;
      end
    end else begin
      stall_run <= '0;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  // Saturating event counters: every PCWrite=0 edge and every flush edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PCWrite && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (IF_Flush && flush_cnt != 16'hFFFF) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed testbench for if_id_stage (default parameters). Perf-counter
// checks are compiled in when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_Flush;
  logic        branch_or_jump_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] IF_ID_pc_plus4;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
  logic        stall_err;
`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  if_id_stage dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .PCWrite              (PCWrite),
    .IF_ID_Write          (IF_ID_Write),
    .IF_Flush             (IF_Flush),
    .branch_or_jump_taken (branch_or_jump_taken),
    .branch_target        (branch_target),
    .instr_in             (instr_in),
    .pc_out               (pc_out),
    .IF_ID_pc_plus4       (IF_ID_pc_plus4),
    .IF_ID_instr          (IF_ID_instr),
    .IF_ID_valid          (IF_ID_valid),
`ifdef IF_ID_PERF_CNT_EN
    .stall_err            (stall_err),
    .stall_cnt            (stall_cnt),
    .flush_cnt            (flush_cnt)
`else
    .stall_err            (stall_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: content is a fixed function of the address.
  function automatic logic [31:0] mem_at(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0013;
  endfunction

  assign instr_in = mem_at(pc_out);

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] exp_instr,
                            input logic [31:0] exp_pc4, input logic exp_valid);
    check({tag, ".instr"}, IF_ID_instr, exp_instr);
    check({tag, ".pc4"},   IF_ID_pc_plus4, exp_pc4);
    check({tag, ".valid"}, {31'b0, IF_ID_valid}, {31'b0, exp_valid});
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n                = 1'b0;
    PCWrite              = 1'b1;
    IF_ID_Write          = 1'b1;
    IF_Flush             = 1'b0;
    branch_or_jump_taken = 1'b0;
    branch_target        = 32'h0;

    // Reset state
    #2;
    check("rst.pc", pc_out, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst.err", {31'b0, stall_err}, 32'h0);

    // Redirect requested while in reset is discarded
    branch_or_jump_taken = 1'b1;
    branch_target        = 32'h0000_0040;
    step();
    check("rst_redirect.pc", pc_out, 32'h0);
    branch_or_jump_taken = 1'b0;

    // Release mid-cycle; first edge fetches address 0
    rst_n = 1'b1;
    step();
    check("fetch1.pc", pc_out, 32'h4);
    check_ifid("fetch1", mem_at(32'h0), 32'h4, 1'b1);
    step();
    check("fetch2.pc", pc_out, 32'h8);
    check_ifid("fetch2", mem_at(32'h4), 32'h8, 1'b1);

    // Load-use stall for one cycle at pc 8
    PCWrite = 1'b0; IF_ID_Write = 1'b0;
    step();
    check("stall.pc", pc_out, 32'h8);
    check_ifid("stall", mem_at(32'h4), 32'h8, 1'b1);
    PCWrite = 1'b1; IF_ID_Write = 1'b1;
    step();
    check("resume.pc", pc_out, 32'hC);
    check_ifid("resume", mem_at(32'h8), 32'hC, 1'b1);

    // PCWrite and IF_ID_Write act independently
    IF_ID_Write = 1'b0;
    step();
    check("indepA.pc", pc_out, 32'h10);
    check_ifid("indepA", mem_at(32'h8), 32'hC, 1'b1);
    PCWrite = 1'b0; IF_ID_Write = 1'b1;
    step();
    check("indepB.pc", pc_out, 32'h10);
    check_ifid("indepB", mem_at(32'h10), 32'h14, 1'b1);

    // Redirect + flush overriding a stall; target gets word-aligned
    branch_or_jump_taken = 1'b1; IF_Flush = 1'b1; branch_target = 32'h0000_0103;
    step();
    check("redir.pc", pc_out, 32'h100);
    check_ifid("redir", 32'h0, 32'h0, 1'b0);
    branch_or_jump_taken = 1'b0; IF_Flush = 1'b0; PCWrite = 1'b1;
    step();
    check("postredir.pc", pc_out, 32'h104);
    check_ifid("postredir", mem_at(32'h100), 32'h104, 1'b1);

    // Flush beats IF/ID hold
    IF_Flush = 1'b1; IF_ID_Write = 1'b0;
    step();
    check("flushhold.pc", pc_out, 32'h108);
    check_ifid("flushhold", 32'h0, 32'h0, 1'b0);
    IF_Flush = 1'b0; IF_ID_Write = 1'b1;

    // Wrap-around at the top of the address space
    branch_or_jump_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    check("top.pc", pc_out, 32'hFFFF_FFFC);
    check_ifid("top", mem_at(32'h108), 32'h10C, 1'b1);
    branch_or_jump_taken = 1'b0;
    step();
    check("wrap.pc", pc_out, 32'h0);
    check_ifid("wrap", mem_at(32'hFFFF_FFFC), 32'h0, 1'b1);

    // Stall watchdog: a redirect edge clears the run
    PCWrite = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("stall10.err", {31'b0, stall_err}, 32'h0);
    branch_or_jump_taken = 1'b1; branch_target = 32'h0000_0200;
    step();
    check("stallclr.pc", pc_out, 32'h200);
    branch_or_jump_taken = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("stall15.err", {31'b0, stall_err}, 32'h0);
    step();
    check("stall16.err", {31'b0, stall_err}, 32'h1);
    check("stall16.pc", pc_out, 32'h200);
    PCWrite = 1'b1;
    step();
    check("sticky.err", {31'b0, stall_err}, 32'h1);
    check("sticky.pc", pc_out, 32'h204);

    // Asynchronous reset mid-cycle clears everything immediately
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.err", {31'b0, stall_err}, 32'h0);
    check("arst.pc", pc_out, 32'h0);
    check_ifid("arst", 32'h0, 32'h0, 1'b0);

`ifdef IF_ID_PERF_CNT_EN
    // Perf counters: 3 stall edges, 2 flush edges
    check("perf0.stall", {16'h0, stall_cnt}, 32'h0);
    check("perf0.flush", {16'h0, flush_cnt}, 32'h0);
    rst_n = 1'b1;
    PCWrite = 1'b0;
    for (int i = 0; i < 3; i++) step();
    PCWrite = 1'b1; IF_Flush = 1'b1;
    for (int i = 0; i < 2; i++) step();
    IF_Flush = 1'b0;
    step();
    check("perf.stall", {16'h0, stall_cnt}, 32'd3);
    check("perf.flush", {16'h0, flush_cnt}, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
